// File: rtl/h264_ct_pkg.sv
// Shared types and constants for the H.264 4x4 forward transform:
// bank/read FSM encodings, coefficient scan tables and transform matrices.
package h264_ct_pkg;

    typedef enum logic [1:0] {
        BK_EMPTY,
        BK_FILLING,
        BK_FULL,
        BK_DRAINING
    } bank_st_e;

    typedef enum logic {
        RD_IDLE,
        RD_DRAIN
    } rd_st_e;

    // Scan position -> raster index r*4+c
    localparam logic [3:0] ZIGZAG_LUT [16] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    localparam logic [3:0] FIELD_LUT [16] = '{
        4'd0, 4'd4, 4'd1, 4'd8, 4'd12, 4'd5, 4'd9, 4'd13,
        4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15
    };

    localparam int CORE_M [4][4] = '{
        '{1,  1,  1,  1},
        '{2,  1, -1, -2},
        '{1, -1, -1,  1},
        '{1, -2,  2, -1}
    };

    localparam int HAD_M [4][4] = '{
        '{1,  1,  1,  1},
        '{1,  1, -1, -1},
        '{1, -1, -1,  1},
        '{1, -1,  1, -1}
    };

    function automatic logic [3:0] scan_pos(input logic field, input logic [3:0] k);
        return field ? FIELD_LUT[k] : ZIGZAG_LUT[k];
    endfunction

endpackage

// File: rtl/h264_ct_butterfly4.sv
// Combinational 4-point transform f = M * x with M the core or Hadamard matrix;
// output grows by 3 bits so no sum can wrap.
module h264_ct_butterfly4
    import h264_ct_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic             mode,
    input  logic [4*W-1:0]   x,
    output logic [4*(W+3)-1:0] f
);

    localparam int unsigned FW = W + 3;

    logic signed [FW-1:0] acc;

    always_comb begin
        f   = '0;
        acc = '0;
        for (int j = 0; j < 4; j++) begin
            acc = '0;
            for (int c = 0; c < 4; c++) begin
                acc = acc + FW'($signed(x[c*W +: W])) * FW'(mode ? HAD_M[j][c] : CORE_M[j][c]);
            end
            f[j*FW +: FW] = acc;
        end
    end

endmodule

// File: rtl/h264_coretransform_pp.sv
// Ping-pong 4x4 forward core transform (optional luma-DC Hadamard) with scanned output.
// Define H264_CT_HADAMARD_EN to let in_mode select the Hadamard transform.
module h264_coretransform_pp
    import h264_ct_pkg::*;
#(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned OUT_W = IN_W + 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*IN_W-1:0] in_row,
    input  logic              in_mode,
    input  logic              in_field,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_coef,
    output logic [3:0]        out_idx,
    output logic              out_last,
    output logic              out_mode
);

    localparam int unsigned RW = IN_W + 3;
    localparam int unsigned CW = IN_W + 6;

    bank_st_e bank_st [2];
    bank_st_e bank_st_n [2];
    rd_st_e   rd_st, rd_st_n;
    logic     wp, wp_n, rp, rp_n;
    logic [1:0] wrow, wrow_n;
    logic [3:0] k, k_n;
    logic     in_ready_n, out_valid_n;
    logic     load, sel_bank;
    logic [3:0] sel_k;

    logic [4*RW-1:0] bank_d [2][4];
    logic            bank_field [2];

    logic             accept;
    logic             row_mode, col_mode;
    logic [4*RW-1:0]  row_f, col_x;
    logic [4*CW-1:0]  col_f;
    logic [3:0]       raster;
    logic signed [CW-1:0] y;
    logic [OUT_W-1:0] coef_n;

    assign accept = in_valid & in_ready;

`ifdef H264_CT_HADAMARD_EN
    logic bank_mode [2];

    // Rows 1..3 follow the mode latched with row 0 of the same block
    assign row_mode = (wrow == 2'd0) ? in_mode : bank_mode[wp];
    assign col_mode = bank_mode[sel_bank];

    always_ff @(posedge CLK) begin
        if (accept && wrow == 2'd0) begin
            bank_mode[wp] <= in_mode;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            out_mode <= 1'b0;
        end else if (load) begin
            out_mode <= col_mode;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = in_mode;
    assign row_mode    = 1'b0;
    assign col_mode    = 1'b0;
    assign out_mode    = 1'b0;
`endif

    h264_ct_butterfly4 #(.W(IN_W)) u_row (
        .mode (row_mode),
        .x    (in_row),
        .f    (row_f)
    );

    h264_ct_butterfly4 #(.W(RW)) u_col (
        .mode (col_mode),
        .x    (col_x),
        .f    (col_f)
    );

    // Row-pass results land in the write bank
    always_ff @(posedge CLK) begin
        if (accept) begin
            bank_d[wp][wrow] <= row_f;
            if (wrow == 2'd0) begin
                bank_field[wp] <= in_field;
            end
        end
    end

    // Column pass for the coefficient presented next
    always_comb begin
        raster = scan_pos(bank_field[sel_bank], sel_k);
        col_x  = '0;
        for (int i = 0; i < 4; i++) begin
            col_x[i*RW +: RW] = bank_d[sel_bank][i][RW*32'(raster[1:0]) +: RW];
        end
        y = col_f[CW*32'(raster[3:2]) +: CW];
`ifdef H264_CT_HADAMARD_EN
        coef_n = col_mode ? OUT_W'($signed(y + CW'(1)) >>> 1) : OUT_W'(y);
`else
        coef_n = OUT_W'(y);
`endif
    end

    always_comb begin
        bank_st_n = bank_st;
        wp_n      = wp;
        rp_n      = rp;
        wrow_n    = wrow;
        rd_st_n   = rd_st;
        k_n       = k;
        load      = 1'b0;
        sel_bank  = rp;
        sel_k     = 4'd0;

        if (accept) begin
            if (wrow == 2'd0) begin
                bank_st_n[wp] = BK_FILLING;
            end
            if (wrow == 2'd3) begin
                bank_st_n[wp] = BK_FULL;
                wp_n          = ~wp;
            end
            wrow_n = wrow + 2'd1;
        end

        // Write side only touches EMPTY/FILLING banks, read side only FULL/DRAINING
        case (rd_st)
            RD_IDLE: begin
                if (bank_st[rp] == BK_FULL) begin
                    load          = 1'b1;
                    rd_st_n       = RD_DRAIN;
                    bank_st_n[rp] = BK_DRAINING;
                    k_n           = 4'd0;
                end
            end
            RD_DRAIN: begin
                if (out_ready) begin
                    if (k != 4'd15) begin
                        load  = 1'b1;
                        k_n   = k + 4'd1;
                        sel_k = k + 4'd1;
                    end else begin
                        bank_st_n[rp] = BK_EMPTY;
                        rp_n          = ~rp;
                        sel_bank      = ~rp;
                        k_n           = 4'd0;
                        if (bank_st[~rp] == BK_FULL) begin
                            load           = 1'b1;
                            bank_st_n[~rp] = BK_DRAINING;
                        end else begin
                            rd_st_n = RD_IDLE;
                        end
                    end
                end
            end
            default: rd_st_n = RD_IDLE;
        endcase

        in_ready_n  = (bank_st_n[wp_n] == BK_EMPTY) || (bank_st_n[wp_n] == BK_FILLING);
        out_valid_n = (rd_st_n == RD_DRAIN);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bank_st[0] <= BK_EMPTY;
            bank_st[1] <= BK_EMPTY;
            rd_st      <= RD_IDLE;
            wp         <= 1'b0;
            rp         <= 1'b0;
            wrow       <= 2'd0;
            k          <= 4'd0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_coef   <= '0;
            out_idx    <= 4'd0;
            out_last   <= 1'b0;
        end else begin
            bank_st   <= bank_st_n;
            rd_st     <= rd_st_n;
            wp        <= wp_n;
            rp        <= rp_n;
            wrow      <= wrow_n;
            k         <= k_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            if (load) begin
                out_coef <= coef_n;
                out_idx  <= sel_k;
                out_last <= (sel_k == 4'd15);
            end
        end
    end

endmodule

// File: tb/tb_h264_coretransform_pp.sv
// Directed bench for h264_coretransform_pp: hand-computed vectors, backpressure and reset cases.
`timescale 1ns/1ps
module tb_h264_coretransform_pp;

    localparam int unsigned IN_W  = 9;
    localparam int unsigned OUT_W = IN_W + 6;

`ifdef H264_CT_HADAMARD_EN
    localparam bit HAD_EN = 1'b1;
`else
    localparam bit HAD_EN = 1'b0;
`endif

    typedef int blk_t [4][4];
    typedef int vec_t [16];

    localparam int ZZ  [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    localparam int FLD [16] = '{0, 4, 1, 8, 12, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4*IN_W-1:0] in_row = '0;
    logic              in_mode = 1'b0;
    logic              in_field = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_coef;
    logic [3:0]        out_idx;
    logic              out_last;
    logic              out_mode;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit col_en = 1'b0;
    bit stab_en = 1'b0;
    bit prev_stall = 1'b0;
    int prev_snap = 0;
    int q_coef[$], q_idx[$], q_last[$], q_mode[$], q_cyc[$];

    h264_coretransform_pp #(.IN_W(IN_W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_mode   (in_mode),
        .in_field  (in_field),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_mode  (out_mode)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output capture and hold-while-stalled check
    always @(negedge CLK) begin
        int snap;
        snap = 32'({out_valid, out_mode, out_last, out_idx, out_coef});
        if (stab_en && prev_stall) chk("hold", snap, prev_snap);
        prev_stall = out_valid && !out_ready;
        prev_snap  = snap;
        if (col_en && out_valid && out_ready) begin
            q_coef.push_back(int'($signed(out_coef)));
            q_idx.push_back(int'(out_idx));
            q_last.push_back(int'(out_last));
            q_mode.push_back(int'(out_mode));
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [4*IN_W-1:0] pack_row(input int a, input int b, input int c, input int d);
        return {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
    endfunction

    function automatic int ref_y(input blk_t x, input bit had, input int r, input int c);
        int cm [4][4];
        int z [4];
        int y;
        if (had) cm = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
        else     cm = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
        for (int i = 0; i < 4; i++) begin
            z[i] = 0;
            for (int j = 0; j < 4; j++) z[i] += x[i][j] * cm[c][j];
        end
        y = 0;
        for (int i = 0; i < 4; i++) y += cm[r][i] * z[i];
        if (had) y = (y + 1) >>> 1;
        return y;
    endfunction

    function automatic vec_t ref_seq(input blk_t x, input bit had, input bit field);
        vec_t e;
        int p;
        for (int k = 0; k < 16; k++) begin
            p = field ? FLD[k] : ZZ[k];
            e[k] = ref_y(x, had, p / 4, p % 4);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_q();
        q_coef.delete(); q_idx.delete(); q_last.delete(); q_mode.delete(); q_cyc.delete();
    endtask

    task automatic send_rows(input blk_t x, input bit mode, input bit field, input int nrows);
        int n;
        for (int r = 0; r < nrows; r++) begin
            in_row   = pack_row(x[r][0], x[r][1], x[r][2], x[r][3]);
            in_mode  = mode;
            in_field = field;
            in_valid = 1'b1;
            n = 0;
            @(negedge CLK);
            while (!in_ready && n < 400) begin
                @(negedge CLK);
                n++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (r == 0) acc_cyc = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_n(input int n);
        int t;
        t = 0;
        while (q_coef.size() < n && t < 600) begin
            @(negedge CLK);
            t++;
        end
        if (q_coef.size() < n) chk("drain_timeout", q_coef.size(), n);
        tick();
    endtask

    task automatic check_seq(input string tag, input vec_t e, input int emode, input int base);
        if (q_coef.size() < base + 16) begin
            chk({tag, "_count"}, q_coef.size(), base + 16);
            return;
        end
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_coef%0d", tag, k), q_coef[base+k], e[k]);
            chk($sformatf("%s_idx%0d", tag, k), q_idx[base+k], k);
            chk($sformatf("%s_last%0d", tag, k), q_last[base+k], (k == 15) ? 1 : 0);
            chk($sformatf("%s_mode%0d", tag, k), q_mode[base+k], emode);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t ones, imp, mx, b1, b2, b3;
        vec_t e;
        int s [4];
        int n;

        s = '{1, 1, -1, -1};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ones[r][c] = 1;
                imp[r][c]  = 0;
                mx[r][c]   = 255 * s[r] * s[c];
                b1[r][c]   = ((1 * 37 + r * 11 + c * 5) % 61) - 30;
                b2[r][c]   = ((2 * 37 + r * 13 + c * 7) % 97) - 48;
                b3[r][c]   = ((3 * 37 + r * 17 + c * 3) % 83) - 41;
            end
        end
        imp[0][0] = 1;

        repeat (3) @(posedge CLK);
        #2;
        RESET = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_coef", int'(out_coef), 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_mode", out_mode, 0);
        tick();

        // All ones, core, zigzag, with latency check
        out_ready = 1'b1;
        col_en = 1'b1;
        clear_q();
        send_rows(ones, 1'b0, 1'b0, 4);
        @(negedge CLK);
        chk("lat_edge1", out_valid, 0);
        @(negedge CLK);
        chk("lat_edge2", out_valid, 1);
        wait_n(16);
        e = '{16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_seq("ones", e, 0, 0);

        // All ones, Hadamard request
        clear_q();
        send_rows(ones, 1'b1, 1'b0, 4);
        wait_n(16);
        e = '{16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e[0] = HAD_EN ? 8 : 16;
        check_seq("had", e, HAD_EN ? 1 : 0, 0);

        // Impulse, core, zigzag
        clear_q();
        send_rows(imp, 1'b0, 1'b0, 4);
        wait_n(16);
        e = '{1, 2, 2, 1, 4, 1, 1, 2, 2, 1, 2, 1, 2, 1, 1, 1};
        check_seq("imp", e, 0, 0);

        // Full-range checkerboard, core, field scan
        clear_q();
        send_rows(mx, 1'b0, 1'b1, 4);
        wait_n(16);
        e = '{0, 0, 0, 0, 0, 9180, 0, -3060, 0, 0, 0, 0, 0, -3060, 0, 1020};
        check_seq("max", e, 0, 0);

        // Three blocks with the sink stalled
        clear_q();
        out_ready = 1'b0;
        stab_en = 1'b1;
        send_rows(b1, 1'b0, 1'b0, 4);
        send_rows(b2, 1'b0, 1'b1, 4);
        @(negedge CLK);
        chk("bp_in_ready_drop", in_ready, 0);
        chk("bp_valid_stalled", out_valid, 1);
        chk("bp_idx_stalled", out_idx, 0);
        repeat (19) @(negedge CLK);
        chk("bp_in_ready_still_low", in_ready, 0);
        tick();
        out_ready = 1'b1;
        send_rows(b3, 1'b1, 1'b0, 4);
        wait_n(48);
        stab_en = 1'b0;
        if (q_cyc.size() >= 17) begin
            chk("bp_b3_gap", acc_cyc - q_cyc[15], 1);
            chk("bp_no_bubble", q_cyc[16] - q_cyc[15], 1);
        end else begin
            chk("bp_count", q_cyc.size(), 48);
        end
        check_seq("bp1", ref_seq(b1, 1'b0, 1'b0), 0, 0);
        check_seq("bp2", ref_seq(b2, 1'b0, 1'b1), 0, 16);
        check_seq("bp3", ref_seq(b3, HAD_EN, 1'b0), HAD_EN ? 1 : 0, 32);

        // Reset in the middle of a drain with a half-filled second bank
        col_en = 1'b0;
        clear_q();
        out_ready = 1'b0;
        send_rows(ones, 1'b0, 1'b0, 4);
        send_rows(b1, 1'b0, 1'b0, 2);
        out_ready = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!(out_valid && out_idx == 4'd7) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("rst_reach_k7", int'(out_valid && out_idx == 4'd7), 1);
        RESET = 1'b0;
        out_ready = 1'b0;
        @(negedge CLK);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_idx", out_idx, 0);
        tick();
        RESET = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge CLK);
            if (out_valid) n++;
        end
        chk("midrst_no_partial", n, 0);
        tick();
        col_en = 1'b1;
        out_ready = 1'b1;
        send_rows(imp, 1'b0, 1'b0, 4);
        wait_n(16);
        e = '{1, 2, 2, 1, 4, 1, 1, 2, 2, 1, 2, 1, 2, 1, 1, 1};
        check_seq("post_rst", e, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/h264_coretransform_pp.md
Name: h264_coretransform_pp

Overview:
- Parametrised 4x4 forward integer transform for the H.264 encoder residual path; successor to the fixed-width core transform.
- Accepts one 4-sample residual row per handshake.
- Computes the core transform Y = C·X·Cᵀ, or optionally the luma-DC Hadamard.
- Emits 16 coefficients per block in zigzag or field scan, with full valid/ready backpressure and ping-pong block buffering. Feeds the quantiser.

Parameters:
- IN_W, 9, signed input sample width; inputs limited to ±(2^(IN_W-1)-1).
- OUT_W, IN_W+6, signed coefficient width (derived; default 15); never overridden.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-low reset
- in_valid  in  1  row beat valid
- in_ready  out  1  row beat accepted when in_valid & in_ready
- in_row  in  4*IN_W  samples x[r][0..3]; column 0 in the LSBs
- in_mode  in  1  0 = core, 1 = Hadamard; sampled on row 0 of the block
- in_field  in  1  0 = zigzag, 1 = field scan; sampled on row 0 of the block
- out_valid  out  1  coefficient valid
- out_ready  in  1  downstream accepts
- out_coef  out  OUT_W  signed coefficient
- out_idx  out  4  scan position 0..15
- out_last  out  1  high with scan position 15
- out_mode  out  1  mode tag of the block being drained

Behaviour:
- Reset values:
  - in_ready = 1.
  - out_valid = 0; out_coef, out_idx, out_last and out_mode = 0.
  - Both banks EMPTY; write and read bank pointers = 0.
- Row pass, combinational per accepted beat:
  - t0 = x0+x3, t1 = x1+x2, t2 = x1−x2, t3 = x0−x3.
  - Core: f = {t0+t1, 2t3+t2, t0−t1, t3−2t2}.
  - Hadamard: f = {t0+t1, t3+t2, t0−t1, t3−t2}.
  - Width is IN_W+3, sign-extended. Row r is written into row r of the write bank on the accepting edge.
- Banks: two 4x4 banks, each with state EMPTY → FILLING → FULL → DRAINING → EMPTY.
  - The 4th accepted row moves the bank to FULL and toggles the write pointer.
  - Mode and scan are stored per bank from row 0.
- in_ready = write bank is EMPTY or FILLING. It is derived from registered state only; there is no combinational path from out_ready.
- Read FSM states: IDLE, DRAIN.
  - IDLE → DRAIN on the edge after the read bank becomes FULL.
  - The output counter k runs 0..15. k advances on each edge where out_valid & out_ready.
  - k = 15 accepted → bank EMPTY, read pointer toggles, return to IDLE. If the other bank is already FULL, DRAIN continues with no bubble.
- Column pass, per output (r,c): the column-c dot product with row r of the same matrix, at full width, registered into out_coef.
  - Hadamard result is (y+1)>>>1.
  - The result is then truncated to OUT_W; truncation is lossless under the input range.
- Scan order, as raster index r*4+c:
  - Zigzag: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
  - Field: 0,4,1,8,12,5,9,13,2,6,10,14,3,7,11,15.
- Latency: 4th row accepted at edge t → first out_valid after edge t+1.
- Output stability: while out_valid & !out_ready, all out_* signals hold stable.
- Simultaneous events: a bank freed by the k=15 handshake is writable from the next cycle (in_ready rises the cycle after).
- Reset mid-operation: partial blocks are discarded and all state returns to reset values; no partial output is emitted.
- Sustained throughput: 1 block per 16 cycles. Input is throttled once both banks are occupied.

Optional Feature:
- Macro: H264_CT_HADAMARD_EN.
- Defined: in_mode selects Hadamard as above.
- Undefined:
  - in_mode is ignored and the core transform is always used.
  - out_mode is tied to 0.
  - The rounding logic is not synthesised.

Decomposition:
- Package h264_ct_pkg holds:
  - bank state enum, read FSM enum;
  - zigzag and field scan LUTs (16 x 4-bit constants);
  - core and Hadamard matrix coefficient constants.
- One sub-module, h264_ct_butterfly4: combinational 4-point row transform (core/Hadamard select). It is instantiated for the row pass and reused in the column pass.

Test Plan:
- All samples = 1, core, zigzag → out_coef 16 at idx 0, 0 at idx 1..15; out_last at idx 15.
- All samples = 1, Hadamard → idx 0 = 8, others 0, out_mode = 1.
  - With the macro undefined, the same stimulus gives idx 0 = 16, out_mode = 0.
- Impulse x[0][0] = 1, core, zigzag → exact sequence 1,2,2,1,4,1,1,2,2,1,2,1,2,1,1,1.
- Max range: x[r][c] = 255·s[r]·s[c] with s = {+,+,−,−}, core, field scan → coefficient (1,1) = 9180 at idx 5, no wrap.
- Three blocks back-to-back with out_ready low for 20 cycles:
  - in_ready drops after block 2 row 3.
  - Outputs hold stable while out_ready is low.
  - Block 3 accepted only after block 1 fully drains.
  - Coefficients are in order and complete.
- RESET low at k = 7 of a drain with a half-filled second bank → next cycle out_valid = 0 and in_ready = 1; a following clean block produces correct results.
